// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: state encoding
// and default port widths.
package reg_write_arbiter_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Write-port bus: load and ALU writeback requests in, register-file write
// port plus status out.
interface reg_write_arbiter_if
    import reg_write_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic                     MEM_REQ;
    logic [ADDR_W-1:0]        MEM_ADDR;
    logic [DATA_W-1:0]        MEM_DATA;
    logic                     ALU_REQ;
    logic [ADDR_W-1:0]        ALU_ADDR;
    logic [DATA_W-1:0]        ALU_DATA;
    logic                     ALU_READY;
    logic                     WRITEEN;
    logic [ADDR_W-1:0]        INADDR;
    logic [DATA_W-1:0]        IN;
    logic [(2**ADDR_W)-1:0]   PENDING;
    logic [7:0]               STALL_CNT;

    modport master (
        output MEM_REQ, MEM_ADDR, MEM_DATA, ALU_REQ, ALU_ADDR, ALU_DATA,
        input  ALU_READY, WRITEEN, INADDR, IN, PENDING, STALL_CNT
    );

    modport slave (
        input  MEM_REQ, MEM_ADDR, MEM_DATA, ALU_REQ, ALU_ADDR, ALU_DATA,
        output ALU_READY, WRITEEN, INADDR, IN, PENDING, STALL_CNT
    );
endinterface

// File: rtl/reg_write_arbiter_wb_hold_buf.sv
// One-entry holding buffer for an ALU writeback that lost the write port to a
// load. Load takes precedence over clear.
module wb_hold_buf
    import reg_write_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    // Buffer storage with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
            data_q  <= data_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates one register-file write port between never-stalled loads and
// back-pressured ALU results, using a one-entry holding buffer.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    reg_write_arbiter_if.slave bus
);
    localparam int NREG = 2**ADDR_W;

    arb_state_e        state_q, state_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [NREG-1:0]   pending_q, pending_d;
    logic [7:0]        stall_q, stall_d;

    logic              buf_load_s, buf_clear_s, buf_valid_s;
    logic [ADDR_W-1:0] buf_addr_s;
    logic [DATA_W-1:0] buf_data_s;
    logic              stall_s;

    wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_hold_buf (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .load_i  (buf_load_s),
        .clear_i (buf_clear_s),
        .addr_i  (bus.ALU_ADDR),
        .data_i  (bus.ALU_DATA),
        .valid_o (buf_valid_s),
        .addr_o  (buf_addr_s),
        .data_o  (buf_data_s)
    );

    // Next-state, write-port selection and buffer control
    always_comb begin
        state_d     = state_q;
        wen_d       = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        buf_load_s  = 1'b0;
        buf_clear_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.MEM_REQ) begin
                    wen_d  = 1'b1;
                    addr_d = bus.MEM_ADDR;
                    data_d = bus.MEM_DATA;
                    if (bus.ALU_REQ) begin
                        buf_load_s = 1'b1;
                        state_d    = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.ALU_REQ) begin
                    wen_d  = 1'b1;
                    addr_d = bus.ALU_ADDR;
                    data_d = bus.ALU_DATA;
                end else begin
                    wen_d = 1'b0;
                end
            end
            HOLD: begin
                if (bus.MEM_REQ) begin
                    wen_d  = 1'b1;
                    addr_d = bus.MEM_ADDR;
                    data_d = bus.MEM_DATA;
                    // A younger load to the same register makes the held ALU value stale
                    if (bus.MEM_ADDR == buf_addr_s) begin
                        buf_clear_s = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    wen_d       = buf_valid_s;
                    addr_d      = buf_addr_s;
                    data_d      = buf_data_s;
                    buf_clear_s = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                buf_clear_s = 1'b1;
            end
        endcase
    end

    // Pending mask and stall counter next values
    always_comb begin
        pending_d = '0;
        if (state_d == HOLD) begin
            pending_d = NREG'(1) << (buf_load_s ? bus.ALU_ADDR : buf_addr_s);
        end else begin
            pending_d = '0;
        end
        if (wen_d) begin
            pending_d = pending_d | (NREG'(1) << addr_d);
        end else begin
            pending_d = pending_d;
        end
        stall_s = bus.ALU_REQ && (state_q == HOLD);
        if (stall_s && (stall_q != 8'hFF)) begin
            stall_d = stall_q + 8'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            pending_q <= '0;
            stall_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            pending_q <= pending_d;
            stall_q   <= stall_d;
        end
    end

    assign bus.ALU_READY = (state_q == IDLE);
    assign bus.WRITEEN   = wen_q;
    assign bus.INADDR    = addr_q;
    assign bus.IN        = data_q;
    assign bus.PENDING   = pending_q;
    assign bus.STALL_CNT = stall_q;
endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, data width of the register-file write port.
REQ-002 Parameter ADDR_W, default 3, register address width; NREG = 2**ADDR_W.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 MEM_REQ  input  1  load-writeback request from the memory stage; never stalled.
REQ-006 MEM_ADDR  input  ADDR_W  destination register of the load.
REQ-007 MEM_DATA  input  DATA_W  load data.
REQ-008 ALU_REQ  input  1  ALU-writeback request; accepted only when ALU_READY=1.
REQ-009 ALU_ADDR  input  ADDR_W  ALU destination register.
REQ-010 ALU_DATA  input  DATA_W  ALU result.
REQ-011 ALU_READY  output  1  high when the ALU request can be accepted this cycle; low only in HOLD.
REQ-012 WRITEEN  output  1  registered write enable to the register file.
REQ-013 INADDR  output  ADDR_W  registered write address.
REQ-014 IN  output  DATA_W  registered write data.
REQ-015 PENDING  output  NREG  per-register mask of accepted writes not yet committed.
REQ-016 STALL_CNT  output  8  saturating count of cycles with ALU_REQ=1 and ALU_READY=0.

Function
REQ-017 Two states: IDLE (hold buffer empty) and HOLD (one buffered ALU write).
REQ-018 Write-port priority: MEM, then the buffered entry, then a new ALU request.
REQ-019 Latency: an accepted request drives WRITEEN/INADDR/IN in the following cycle. The register file commits at the end of that cycle.
REQ-020 IDLE with MEM_REQ and ALU_REQ both high: MEM is issued and ALU is captured into the buffer; transition to HOLD.
REQ-021 IDLE with exactly one request: that request is issued and the state stays IDLE.
REQ-022 IDLE with no request: WRITEEN=0 next cycle; INADDR and IN hold their previous values.
REQ-023 HOLD without MEM_REQ: the buffered entry is issued; transition to IDLE.
REQ-024 HOLD with MEM_REQ and MEM_ADDR differing from the buffer address: MEM is issued and the state stays HOLD.
REQ-025 HOLD with MEM_REQ and MEM_ADDR equal to the buffer address: MEM is issued and the buffered entry is discarded as superseded by the younger load; transition to IDLE.
REQ-026 ALU_READY = (state==IDLE), decoded from registered state only. ALU_REQ while ALU_READY=0 is ignored, and the requester holds its request.
REQ-027 Same-cycle MEM and ALU to the same address in IDLE: MEM is written first and ALU last, so the ALU value is final.
REQ-028 PENDING = one-hot(buffer address) when in HOLD, OR one-hot(INADDR) when WRITEEN=1; otherwise 0.
REQ-029 STALL_CNT increments by 1 per stalled cycle and saturates at 255; it never wraps.

Reset
REQ-030 RESET sampled high sets: state=IDLE, WRITEEN=0, INADDR=0, IN=0, buffer cleared, PENDING=0, STALL_CNT=0.
REQ-031 RESET overrides all requests in the same cycle; those requests are dropped.
REQ-032 RESET in HOLD discards the buffered write.
REQ-033 ALU_READY=1 in the first cycle after reset.

Structure
REQ-034 A shared package holds the state enumeration (IDLE, HOLD) and the DATA_W/ADDR_W defaults.
REQ-035 A single sub-module, wb_hold_buf, implements the one-entry buffer with load, clear and valid, holding address and data.

Verification
REQ-036 Reset: assert RESET for 2 cycles with both requests high -> WRITEEN=0, PENDING=0, ALU_READY=1, STALL_CNT=0.
REQ-037 Conflict: in IDLE, MEM(R2,0x11) and ALU(R5,0x22) in the same cycle -> cycle+1: write R2=0x11; cycle+2: write R5=0x22; PENDING cycle+1 = 0x24.
REQ-038 Squash: HOLD holding ALU(R3,0xAA) with MEM(R3,0x55) -> write R3=0x55, then IDLE, with no 0xAA write.
REQ-039 Back-to-back: MEM_REQ for 4 cycles while in HOLD with ALU asserted -> ALU_READY=0 for 4 cycles, STALL_CNT=4, and the buffered write issues in the cycle after MEM drops.
REQ-040 Saturation: hold a stall for 300 cycles -> STALL_CNT=255.
REQ-041 Reset mid-HOLD: RESET while the buffer holds (R7,0x3C) -> no write of 0x3C follows and PENDING=0.
